pipe_cla_addsub: RTL and testbench
==================================

PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand/result width; multiple of 4*STAGES.
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth, legal values 1, 2, 4; each stage covers WIDTH/STAGES bits.
REQ-003 SHALL have parameter TAG_W, default 4: width of the sideband tag carried with each operation.
REQ-004 SHALL have port clock, input, 1: single clock, all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1: discard all in-flight operations.
REQ-007 SHALL have port in_valid, input, 1: operands present.
REQ-008 SHALL have port in_ready, output, 1: block accepts this cycle.
REQ-009 SHALL have port x, input, WIDTH: operand A.
REQ-010 SHALL have port y, input, WIDTH: operand B.
REQ-011 SHALL have port sub, input, 1: 0 = x+y, 1 = x-y.
REQ-012 SHALL have port in_tag, input, TAG_W: sideband tag.
REQ-013 SHALL have port out_valid, output, 1: result present.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts.
REQ-015 SHALL have port res, output, WIDTH: sum/difference modulo 2^WIDTH.
REQ-016 SHALL have port cout, output, 1: carry out of MSB (for sub: 1 = no borrow).
REQ-017 SHALL have port ovf, output, 1: two's-complement signed overflow.
REQ-018 SHALL have port zero, output, 1: res == 0.
REQ-019 SHALL have port out_tag, output, TAG_W: tag of the presented result.

Function
REQ-020 SHALL compute x + (sub ? ~y : y) + sub, with 4-bit carry-lookahead groups and group-level lookahead within each stage.
REQ-021 SHALL compute stage k (k=0..STAGES-1) on bits [(k+1)*W/S-1 : k*W/S], registering the chunk carry-out as the carry-in of stage k+1; unprocessed upper operand bits, sub, tag and valid travel with the operation.
REQ-022 SHALL present a result exactly STAGES cycles after the accepting edge when out_ready is held high.
REQ-023 SHALL accept an operation on a rising edge where in_valid && in_ready.
REQ-024 SHALL drive in_ready = !flush && (out_ready || !out_valid); the pipeline stalls globally when out_valid && !out_ready.
REQ-025 SHALL hold res, cout, ovf, zero and out_tag stable while out_valid && !out_ready.
REQ-026 SHALL sustain one accept and one retire per cycle with no bubbles when out_ready is held high.
REQ-027 SHALL compute ovf = (A[MSB] == B'[MSB]) && (res[MSB] != A[MSB]), where B' is the possibly inverted y.
REQ-028 SHALL derive zero from the final result register.
REQ-029 SHALL, on flush, clear every stage valid bit at the next edge (out_valid = 0 the following cycle); no operation is accepted in a flush cycle.
REQ-030 SHALL give reset priority over flush; flush SHALL have priority over accept and stall.
REQ-031 SHALL, with STAGES=1, reduce to a single registered full-width adder with latency 1.

Reset
REQ-032 SHALL, on reset, clear all stage valid bits and drive out_valid=0, res=0, cout=0, ovf=0, out_tag=0, zero=1.
REQ-033 SHALL drive in_ready=1 in the first cycle after reset deasserts (flush low).
REQ-034 SHALL discard any operation in flight when reset asserts; none reappears afterwards.

Verification (WIDTH=64, STAGES=2)
REQ-035 SHALL pass: add x=0xFFFF_FFFF_FFFF_FFFF, y=1, tag=3 -> 2 cycles later res=0, cout=1, zero=1, ovf=0, out_tag=3 (carry crosses the stage boundary).
REQ-036 SHALL pass: sub x=5, y=7 -> res=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0, zero=0.
REQ-037 SHALL pass: add x=0x7FFF_FFFF_FFFF_FFFF, y=1 -> res=0x8000_0000_0000_0000, ovf=1, cout=0; sub x=0x8000_0000_0000_0000, y=1 -> ovf=1, cout=1.
REQ-038 SHALL pass: tags 1..6 issued back-to-back with out_ready low for 3 cycles mid-stream -> six results retire in tag order, none lost or duplicated, outputs stable during stall.
REQ-039 SHALL pass: two ops in flight then flush for 1 cycle -> out_valid=0 next cycle, neither result appears, in_ready=0 during flush, the next op completes with latency 2.
REQ-040 SHALL pass: reset asserted with ops in flight -> all outputs at reset values next cycle, no stale result after release.

Source files
------------

// File: rtl/pipe_cla_addsub.sv
// pipe_cla_addsub: pipelined carry-lookahead adder/subtractor with tag sideband,
// global stall on output backpressure and single-cycle flush.
module pipe_cla_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int C = WIDTH / STAGES;

    // 4-bit lookahead groups chained through group generate/propagate terms
    function automatic logic [C:0] cla(input logic [C-1:0] a, input logic [C-1:0] b, input logic ci);
        logic [C-1:0] g, p, c;
        logic [C/4:0] gc;
        g = a & b;
        p = a ^ b;
        gc[0] = ci;
        for (int j = 0; j < C/4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (&p[4*j +: 2] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (&p[4*j+1 +: 2] & g[4*j])
                     | (&p[4*j +: 3] & gc[j]);
            gc[j+1]  = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (&p[4*j+2 +: 2] & g[4*j+1])
                     | (&p[4*j+1 +: 3] & g[4*j]) | (&p[4*j +: 4] & gc[j]);
        end
        return {gc[C/4], p ^ c};
    endfunction

    // Every register moves together; a stall or flush freezes all data.
    assign in_ready = !flush && (out_ready || !out_valid);

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int UW = WIDTH - k * C;
        logic [UW-1:0]        a_i, b_i;
        logic                 c_i, v_i;
        logic [TAG_W-1:0]     t_i;
        logic [C:0]           s;
        logic [(k+1)*C-1:0]   r_n, r_q;
        logic                 c_q, v_q;
        logic [TAG_W-1:0]     t_q;

        if (k == 0) begin : g_first
            assign a_i = x;
            assign b_i = {WIDTH{sub}} ^ y;
            assign c_i = sub;
            assign v_i = in_valid;
            assign t_i = in_tag;
            assign r_n = s[C-1:0];
        end else begin : g_next
            assign a_i = g_st[k-1].g_fwd.a_q;
            assign b_i = g_st[k-1].g_fwd.b_q;
            assign c_i = g_st[k-1].c_q;
            assign v_i = g_st[k-1].v_q;
            assign t_i = g_st[k-1].t_q;
            assign r_n = {s[C-1:0], g_st[k-1].r_q};
        end

        assign s = cla(a_i[C-1:0], b_i[C-1:0], c_i);

        always_ff @(posedge clock) begin
            if (reset) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
                t_q <= '0;
            end else if (flush) begin
                v_q <= 1'b0;
            end else if (in_ready) begin
                v_q <= v_i;
                c_q <= s[C];
                r_q <= r_n;
                t_q <= t_i;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [UW-C-1:0] a_q, b_q;
            always_ff @(posedge clock) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (in_ready) begin
                    a_q <= a_i[UW-1:C];
                    b_q <= b_i[UW-1:C];
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic o_q;
            always_ff @(posedge clock) begin
                if (reset)
                    o_q <= 1'b0;
                else if (in_ready)
                    o_q <= (a_i[C-1] == b_i[C-1]) && (s[C-1] != a_i[C-1]);
            end
        end
    end

    assign out_valid = g_st[STAGES-1].v_q;
    assign res       = g_st[STAGES-1].r_q;
    assign cout      = g_st[STAGES-1].c_q;
    assign out_tag   = g_st[STAGES-1].t_q;
    assign ovf       = g_st[STAGES-1].g_last.o_q;
    assign zero      = ~|res;
endmodule

// File: tb/tb_pipe_cla_addsub.sv
// tb_pipe_cla_addsub: directed checks of the 64-bit, 2-stage adder/subtractor.
module tb_pipe_cla_addsub;
    logic        clock, reset, flush, in_valid, in_ready, sub, out_valid, out_ready;
    logic [63:0] x, y, res;
    logic [3:0]  in_tag, out_tag;
    logic        cout, ovf, zero;
    int          n_cmp, n_bad;

    pipe_cla_addsub #(.WIDTH(64), .STAGES(2), .TAG_W(4)) dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .sub(sub), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .cout(cout), .ovf(ovf), .zero(zero), .out_tag(out_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Presents one operation for a single edge, then drops in_valid.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s, input logic [3:0] t);
        x = a; y = b; sub = s; in_tag = t; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; sub = 1'b0; in_tag = '0;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_cmp++; if (res !== 64'h0) begin n_bad++; $display("FAIL rst_res: got %h want 0", res); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL rst_cout: got %b want 0", cout); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL rst_zero: got %b want 1", zero); end
        n_cmp++; if (out_tag !== 4'h0) begin n_bad++; $display("FAIL rst_tag: got %h want 0", out_tag); end
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_carry;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 4'd3);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL carry_early: got %b want 0", out_valid); end
        @(posedge clock); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL carry_valid: got %b want 1", out_valid); end
        n_cmp++; if (res !== 64'h0) begin n_bad++; $display("FAIL carry_res: got %h want 0", res); end
        n_cmp++; if (cout !== 1'b1) begin n_bad++; $display("FAIL carry_cout: got %b want 1", cout); end
        n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL carry_zero: got %b want 1", zero); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL carry_ovf: got %b want 0", ovf); end
        n_cmp++; if (out_tag !== 4'd3) begin n_bad++; $display("FAIL carry_tag: got %h want 3", out_tag); end
    endtask

    task automatic test_sub;
        send(64'd5, 64'd7, 1'b1, 4'd4);
        @(posedge clock); #1;
        n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL sub_res: got %h want fffffffffffffffe", res); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL sub_cout: got %b want 0", cout); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL sub_ovf: got %b want 0", ovf); end
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL sub_zero: got %b want 0", zero); end
        n_cmp++; if (out_tag !== 4'd4) begin n_bad++; $display("FAIL sub_tag: got %h want 4", out_tag); end
    endtask

    task automatic test_ovf;
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 4'd1);
        send(64'h8000_0000_0000_0000, 64'h1, 1'b1, 4'd2);
        n_cmp++; if (res !== 64'h8000_0000_0000_0000) begin n_bad++; $display("FAIL ovf_add_res: got %h want 8000000000000000", res); end
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_add_ovf: got %b want 1", ovf); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL ovf_add_cout: got %b want 0", cout); end
        @(posedge clock); #1;
        n_cmp++; if (res !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL ovf_sub_res: got %h want 7fffffffffffffff", res); end
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sub_ovf: got %b want 1", ovf); end
        n_cmp++; if (cout !== 1'b1) begin n_bad++; $display("FAIL ovf_sub_cout: got %b want 1", cout); end
        n_cmp++; if (out_tag !== 4'd2) begin n_bad++; $display("FAIL ovf_sub_tag: got %h want 2", out_tag); end
    endtask

    // Tag t carries x=100*t, y=t, so the expected sum is 101*t.
    task automatic test_back_to_back;
        int issued, exp_t;
        logic acc;
        issued = 0; exp_t = 1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 6);
            in_valid = issued < 6;
            x = 64'(issued + 1) * 100; y = 64'(issued + 1); sub = 1'b0; in_tag = 4'(issued + 1);
            @(negedge clock);
            acc = in_valid && in_ready;
            if (cyc == 4) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_ready: got %b want 0", in_ready); end
            end
            if (out_valid) begin
                n_cmp++; if (out_tag !== 4'(exp_t)) begin n_bad++; $display("FAIL b2b_tag: got %0d want %0d", out_tag, exp_t); end
                n_cmp++; if (res !== 64'(exp_t) * 101) begin n_bad++; $display("FAIL b2b_res: got %0d want %0d", res, exp_t * 101); end
                if (out_ready) exp_t++;
            end
            @(posedge clock); #1;
            if (acc) issued++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (exp_t != 7) begin n_bad++; $display("FAIL b2b_retired: got %0d want 6", exp_t - 1); end
    endtask

    task automatic test_flush;
        flush = 1'b1; x = 64'd1; y = 64'd1; sub = 1'b0; in_tag = 4'd12; in_valid = 1'b1;
        @(negedge clock);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_idle_ready: got %b want 0", in_ready); end
        @(posedge clock); #1;
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_blocked_op: got %b want 0", out_valid); end
            @(posedge clock); #1;
        end
        send(64'd20, 64'd1, 1'b0, 4'd8);
        send(64'd30, 64'd1, 1'b0, 4'd9);
        flush = 1'b1; out_ready = 1'b0;
        @(negedge clock);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        @(posedge clock); #1;
        flush = 1'b0; out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_stale: got tag %0d valid %b want 0", out_tag, out_valid); end
            @(posedge clock); #1;
        end
        send(64'd10, 64'd3, 1'b1, 4'd11);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_next_early: got %b want 0", out_valid); end
        @(posedge clock); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_next_valid: got %b want 1", out_valid); end
        n_cmp++; if (res !== 64'd7) begin n_bad++; $display("FAIL flush_next_res: got %0d want 7", res); end
        n_cmp++; if (cout !== 1'b1) begin n_bad++; $display("FAIL flush_next_cout: got %b want 1", cout); end
        n_cmp++; if (out_tag !== 4'd11) begin n_bad++; $display("FAIL flush_next_tag: got %0d want 11", out_tag); end
    endtask

    task automatic test_reset_inflight;
        send(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0, 4'd5);
        send(64'd1, 64'd2, 1'b0, 4'd6);
        n_cmp++; if (out_tag !== 4'd5 || out_valid !== 1'b1) begin n_bad++; $display("FAIL rif_pre: got tag %0d valid %b want 5/1", out_tag, out_valid); end
        reset = 1'b1; out_ready = 1'b0;
        @(posedge clock); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rif_valid: got %b want 0", out_valid); end
        n_cmp++; if (res !== 64'h0) begin n_bad++; $display("FAIL rif_res: got %h want 0", res); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL rif_cout: got %b want 0", cout); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rif_ovf: got %b want 0", ovf); end
        n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL rif_zero: got %b want 1", zero); end
        n_cmp++; if (out_tag !== 4'h0) begin n_bad++; $display("FAIL rif_tag: got %h want 0", out_tag); end
        reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rif_stale: got tag %0d valid %b want 0", out_tag, out_valid); end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        test_reset();
        test_carry();
        test_sub();
        test_ovf();
        @(posedge clock); #1;
        test_back_to_back();
        test_flush();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
